// File: rtl/sched_dispatch_if.sv
// Queue-side and bank-side signal bundle for sched_dispatch.
// Stat outputs exist only when DISPATCH_STATS_EN is defined.
interface sched_dispatch_if #(
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned NUM_BANKS  = 4
`ifdef DISPATCH_STATS_EN
  ,
  parameter int unsigned STAT_WIDTH = 16
`endif
);
  localparam int unsigned BANK_W = ($clog2(NUM_BANKS) > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned OPND_W = FIFO_WIDTH - 2 - BANK_W;

  logic                  q_empty;
  logic                  q_read_en;
  logic [FIFO_WIDTH-1:0] q_data;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [1:0]            issue_op;
  logic [BANK_W-1:0]     issue_bank;
  logic [OPND_W-1:0]     issue_operand;
  logic [NUM_BANKS-1:0]  bank_busy;
  logic                  idle;
`ifdef DISPATCH_STATS_EN
  logic [STAT_WIDTH-1:0] stat_issued;
  logic [STAT_WIDTH-1:0] stat_nops;
`endif

  modport master (
    input  q_empty, q_data, issue_ready,
    output q_read_en, issue_valid, issue_op, issue_bank, issue_operand,
           bank_busy, idle
`ifdef DISPATCH_STATS_EN
    , output stat_issued, stat_nops
`endif
  );

  modport slave (
    output q_empty, q_data, issue_ready,
    input  q_read_en, issue_valid, issue_op, issue_bank, issue_operand,
           bank_busy, idle
`ifdef DISPATCH_STATS_EN
    , input stat_issued, stat_nops
`endif
  );
endinterface

// File: rtl/sched_dispatch.sv
// In-order dispatcher: pops the scheduler queue, holds one command and issues it once its bank timer is idle.
// Optional macro DISPATCH_STATS_EN adds saturating stat_issued / stat_nops counters.
module sched_dispatch #(
  parameter int unsigned FIFO_WIDTH  = 8,
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned BUSY_CYCLES = 3
`ifdef DISPATCH_STATS_EN
  ,
  parameter int unsigned STAT_WIDTH  = 16
`endif
) (
  input logic              clk,
  input logic              rst,
  sched_dispatch_if.master bus
);
  localparam int unsigned BANK_W = ($clog2(NUM_BANKS) > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned OPND_W = FIFO_WIDTH - 2 - BANK_W;
  localparam int unsigned TMR_W  = ($clog2(BUSY_CYCLES + 1) > 1) ? $clog2(BUSY_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [FIFO_WIDTH-1:0] r_hold;
  logic [TMR_W-1:0]      r_timer [NUM_BANKS];
  logic [NUM_BANKS-1:0]  w_busy;
  logic [1:0]            w_op;
  logic [BANK_W-1:0]     w_bank;
  logic                  w_is_nop;
  logic                  w_read_en;
  logic                  w_issue_valid;
  logic                  w_accept;
  logic                  w_nop_drop;

  assign w_op     = r_hold[FIFO_WIDTH-1 -: 2];
  assign w_bank   = r_hold[FIFO_WIDTH-3 -: BANK_W];
  assign w_is_nop = (w_op == 2'b00);

  always_comb begin
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      w_busy[b] = (r_timer[b] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Reset gates the pop and the offer so nothing leaks out while rst is held.
  always_comb begin
    w_next        = r_state;
    w_read_en     = 1'b0;
    w_issue_valid = 1'b0;
    w_accept      = 1'b0;
    w_nop_drop    = 1'b0;
    if (!rst) begin
      unique case (r_state)
        S_IDLE: begin
          if (!bus.q_empty) begin
            w_read_en = 1'b1;
            w_next    = S_WAIT;
          end
        end
        S_WAIT: begin
          w_next = S_HOLD;
        end
        S_HOLD: begin
          w_issue_valid = !w_is_nop && !w_busy[w_bank];
          w_accept      = w_issue_valid && bus.issue_ready;
          w_nop_drop    = w_is_nop;
          if (w_accept || w_nop_drop) begin
            w_read_en = !bus.q_empty;
            w_next    = bus.q_empty ? S_IDLE : S_WAIT;
          end
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (r_state == S_WAIT) begin
      r_hold <= bus.q_data;
    end
  end

  // A fresh load on accept takes priority over the countdown.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      if (rst) begin
        r_timer[b] <= '0;
      end else if (w_accept && (w_bank == BANK_W'(b))) begin
        r_timer[b] <= TMR_W'(BUSY_CYCLES);
      end else if (r_timer[b] != '0) begin
        r_timer[b] <= r_timer[b] - TMR_W'(1);
      end
    end
  end

  assign bus.q_read_en     = w_read_en;
  assign bus.issue_valid   = w_issue_valid;
  assign bus.issue_op      = w_op;
  assign bus.issue_bank    = w_bank;
  assign bus.issue_operand = r_hold[OPND_W-1:0];
  assign bus.bank_busy     = w_busy;
  assign bus.idle          = (r_state == S_IDLE) && (w_busy == '0);

`ifdef DISPATCH_STATS_EN
  logic [STAT_WIDTH-1:0] r_stat_issued;
  logic [STAT_WIDTH-1:0] r_stat_nops;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_issued <= '0;
      r_stat_nops   <= '0;
    end else begin
      if (w_accept && (r_stat_issued != '1)) begin
        r_stat_issued <= r_stat_issued + STAT_WIDTH'(1);
      end
      if (w_nop_drop && (r_stat_nops != '1)) begin
        r_stat_nops <= r_stat_nops + STAT_WIDTH'(1);
      end
    end
  end

  assign bus.stat_issued = r_stat_issued;
  assign bus.stat_nops   = r_stat_nops;
`endif
endmodule

// File: tb/tb_sched_dispatch.sv
// Bench for sched_dispatch: directed timing scenarios plus a randomized run against an in-order/bank-timer model.
module tb_sched_dispatch;
  localparam int unsigned FW   = 8;
  localparam int unsigned NB   = 4;
  localparam int unsigned BUSY = 3;

  logic       clk;
  logic       rst;
  logic       ready;
  logic       flush;
  logic [7:0] qd = '0;
  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

`ifdef DISPATCH_STATS_EN
  sched_dispatch_if #(.FIFO_WIDTH(FW), .NUM_BANKS(NB), .STAT_WIDTH(16)) bus ();
  sched_dispatch #(.FIFO_WIDTH(FW), .NUM_BANKS(NB), .BUSY_CYCLES(BUSY), .STAT_WIDTH(16))
    dut (.clk(clk), .rst(rst), .bus(bus));
`else
  sched_dispatch_if #(.FIFO_WIDTH(FW), .NUM_BANKS(NB)) bus ();
  sched_dispatch #(.FIFO_WIDTH(FW), .NUM_BANKS(NB), .BUSY_CYCLES(BUSY))
    dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue model: registered read data one cycle after the pop.
  assign bus.q_empty     = (wr_ptr == rd_ptr);
  assign bus.q_data      = qd;
  assign bus.issue_ready = ready;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (!rst && bus.q_read_en) begin
      qd     <= mem[8'(rd_ptr)];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[8'(wr_ptr)] = d;
    wr_ptr++;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      #1;
      if (bus.idle && bus.q_empty) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1; ready = 1'b0; flush = 1'b0;
    step(); step();
    push(8'h5A); push(8'h0F); push(8'hC3);
    #1;
    n_checks++; if (bus.q_read_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", bus.q_read_en); else n_pass++;
    n_checks++; if (bus.issue_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.issue_valid); else n_pass++;
    n_checks++; if ({bus.issue_op, bus.issue_bank, bus.issue_operand} !== 8'h00)
      $display("FAIL reset_fields: got %h want 00", {bus.issue_op, bus.issue_bank, bus.issue_operand}); else n_pass++;
    n_checks++; if (bus.bank_busy !== 4'b0000) $display("FAIL reset_busy: got %b want 0000", bus.bank_busy); else n_pass++;
    n_checks++; if (bus.idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", bus.idle); else n_pass++;
`ifdef DISPATCH_STATS_EN
    n_checks++; if (bus.stat_issued !== 16'd0 || bus.stat_nops !== 16'd0)
      $display("FAIL reset_stats: got %0d/%0d want 0/0", bus.stat_issued, bus.stat_nops); else n_pass++;
`endif
    step(); #1;
    n_checks++; if (bus.q_read_en !== 1'b0) $display("FAIL reset_rd_en_hold: got %b want 0", bus.q_read_en); else n_pass++;
    step(); rst = 1'b0; #1;
    n_checks++; if (bus.q_read_en !== 1'b1) $display("FAIL reset_first_pop: got %b want 1", bus.q_read_en); else n_pass++;
    ready = 1'b1;
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL reset_drain: got timeout want idle"); else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    step(); push(8'h5A); #1;
    n_checks++; if (bus.q_read_en !== 1'b1) $display("FAIL single_c0_pop: got %b want 1", bus.q_read_en); else n_pass++;
    step(); #1;
    n_checks++; if (bus.q_read_en !== 1'b0 || bus.issue_valid !== 1'b0)
      $display("FAIL single_c1: got rd=%b v=%b want 0/0", bus.q_read_en, bus.issue_valid); else n_pass++;
    step(); #1;
    n_checks++; if (bus.issue_valid !== 1'b1) $display("FAIL single_c2_valid: got %b want 1", bus.issue_valid); else n_pass++;
    n_checks++; if (bus.issue_op !== 2'd1 || bus.issue_bank !== 2'd1 || bus.issue_operand !== 4'hA)
      $display("FAIL single_c2_fields: got %0d/%0d/%h want 1/1/a", bus.issue_op, bus.issue_bank, bus.issue_operand); else n_pass++;
    for (int k = 3; k <= 6; k++) begin
      step(); #1;
      n_checks++; if (bus.bank_busy !== ((k <= 5) ? 4'b0010 : 4'b0000))
        $display("FAIL single_busy_c%0d: got %b want %b", k, bus.bank_busy, (k <= 5) ? 4'b0010 : 4'b0000); else n_pass++;
      n_checks++; if (bus.idle !== (k == 6))
        $display("FAIL single_idle_c%0d: got %b want %b", k, bus.idle, (k == 6)); else n_pass++;
    end
    wait_idle(ok);
  endtask

  task automatic test_back_to_back();
    bit ok;
    // Both entries target bank 0 (bits [5:4] = 00).
    step(); push(8'h41); push(8'hC2); #1;
    step(); #1;
    step(); #1;
    n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_bank !== 2'd0 || bus.q_read_en !== 1'b1)
      $display("FAIL b2b_first: got v=%b bank=%0d rd=%b want 1/0/1", bus.issue_valid, bus.issue_bank, bus.q_read_en); else n_pass++;
    for (int k = 3; k <= 6; k++) begin
      step(); #1;
      n_checks++; if (bus.issue_valid !== (k == 6))
        $display("FAIL b2b_valid_t+%0d: got %b want %b", k - 2, bus.issue_valid, (k == 6)); else n_pass++;
    end
    n_checks++; if (bus.issue_op !== 2'd3 || bus.issue_operand !== 4'h2)
      $display("FAIL b2b_second_fields: got %0d/%h want 3/2", bus.issue_op, bus.issue_operand); else n_pass++;
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL b2b_drain: got timeout want idle"); else n_pass++;
  endtask

  task automatic test_two_banks();
    bit ok;
    step(); push(8'h41); push(8'h61); #1;
    step(); step(); step(); step(); #1;
    n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_bank !== 2'd2)
      $display("FAIL banks_second_t+2: got v=%b bank=%0d want 1/2", bus.issue_valid, bus.issue_bank); else n_pass++;
    step(); #1;
    n_checks++; if (bus.bank_busy !== 4'b0101) $display("FAIL banks_busy_t+3: got %b want 0101", bus.bank_busy); else n_pass++;
    wait_idle(ok);
  endtask

  task automatic test_nop();
    bit ok;
`ifdef DISPATCH_STATS_EN
    logic [15:0] iss0, nop0;
    iss0 = bus.stat_issued; nop0 = bus.stat_nops;
`endif
    step(); push(8'h41); push(8'h0F); push(8'h61); #1;
    step(); step(); step(); step(); #1;
    n_checks++; if (bus.issue_valid !== 1'b0 || bus.q_read_en !== 1'b1)
      $display("FAIL nop_hold: got v=%b rd=%b want 0/1", bus.issue_valid, bus.q_read_en); else n_pass++;
    step(); #1;
    n_checks++; if (bus.issue_valid !== 1'b0) $display("FAIL nop_wait_valid: got %b want 0", bus.issue_valid); else n_pass++;
    step(); #1;
    n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_bank !== 2'd2 || bus.issue_op !== 2'd1)
      $display("FAIL nop_next: got v=%b bank=%0d op=%0d want 1/2/1", bus.issue_valid, bus.issue_bank, bus.issue_op); else n_pass++;
    wait_idle(ok);
`ifdef DISPATCH_STATS_EN
    n_checks++; if (bus.stat_issued - iss0 !== 16'd2 || bus.stat_nops - nop0 !== 16'd1)
      $display("FAIL nop_stats: got %0d/%0d want 2/1", bus.stat_issued - iss0, bus.stat_nops - nop0); else n_pass++;
`endif
  endtask

  task automatic test_stall_and_reset();
    step(); ready = 1'b0; push(8'h72); push(8'h81); #1;
    step(); step(); #1;
    for (int k = 2; k <= 6; k++) begin
      if (k > 2) begin step(); #1; end
      n_checks++; if (bus.issue_valid !== 1'b1 || {bus.issue_op, bus.issue_bank, bus.issue_operand} !== 8'h72 || bus.q_read_en !== 1'b0)
        $display("FAIL stall_c%0d: got v=%b f=%h rd=%b want 1/72/0", k, bus.issue_valid,
                 {bus.issue_op, bus.issue_bank, bus.issue_operand}, bus.q_read_en); else n_pass++;
    end
    step(); ready = 1'b1; #1;
    n_checks++; if (bus.q_read_en !== 1'b1) $display("FAIL stall_accept_pop: got %b want 1", bus.q_read_en); else n_pass++;
    step(); ready = 1'b0; #1;
    step(); #1;
    n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_op !== 2'd2)
      $display("FAIL stall_second_hold: got v=%b op=%0d want 1/2", bus.issue_valid, bus.issue_op); else n_pass++;
    step(); rst = 1'b1; flush = 1'b1; #1;
    n_checks++; if (bus.q_read_en !== 1'b0) $display("FAIL midhold_rst_rd: got %b want 0", bus.q_read_en); else n_pass++;
    step(); rst = 1'b0; flush = 1'b0; ready = 1'b1; #1;
    n_checks++; if (bus.issue_valid !== 1'b0 || {bus.issue_op, bus.issue_bank, bus.issue_operand} !== 8'h00)
      $display("FAIL midhold_rst_valid: got v=%b f=%h want 0/00", bus.issue_valid,
               {bus.issue_op, bus.issue_bank, bus.issue_operand}); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      n_checks++; if (bus.issue_valid !== 1'b0 || bus.idle !== 1'b1)
        $display("FAIL midhold_lost_%0d: got v=%b idle=%b want 0/1", k, bus.issue_valid, bus.idle); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q [$];
    logic [7:0] d, e, fields, prev_fields;
    logic [NB-1:0] mb;
    int last_acc [NB];
    int last_any, pushed, accepted, nops;
    bit prev_stall, done;
`ifdef DISPATCH_STATS_EN
    logic [15:0] iss0, nop0;
    iss0 = bus.stat_issued; nop0 = bus.stat_nops;
`endif
    for (int b = 0; b < int'(NB); b++) last_acc[b] = -100;
    last_any = -100; pushed = 0; accepted = 0; nops = 0; prev_stall = 1'b0; done = 1'b0;
    prev_fields = '0;
    for (int i = 0; i < 20000 && !done; i++) begin
      step();
      if (pushed < 120 && $urandom_range(0, 2) == 0) begin
        d = 8'($urandom);
        push(d);
        pushed++;
        if (d[7:6] != 2'b00) exp_q.push_back(d); else nops++;
      end
      ready = ($urandom_range(0, 3) != 0);
      #1;
      fields = {bus.issue_op, bus.issue_bank, bus.issue_operand};
      for (int b = 0; b < int'(NB); b++) mb[b] = (cyc - last_acc[b] >= 1) && (cyc - last_acc[b] <= int'(BUSY));
      n_checks++; if (bus.bank_busy !== mb) $display("FAIL rnd_busy@%0d: got %b want %b", cyc, bus.bank_busy, mb); else n_pass++;
      n_checks++; if (bus.q_read_en && bus.q_empty) $display("FAIL rnd_overread@%0d: got rd=1 want 0", cyc); else n_pass++;
      if (bus.issue_valid) begin
        n_checks++; if (mb[bus.issue_bank]) $display("FAIL rnd_busy_issue@%0d: got valid on busy bank %0d want 0", cyc, bus.issue_bank); else n_pass++;
      end
      if (prev_stall) begin
        n_checks++; if (bus.issue_valid !== 1'b1 || fields !== prev_fields)
          $display("FAIL rnd_stable@%0d: got v=%b f=%h want 1/%h", cyc, bus.issue_valid, fields, prev_fields); else n_pass++;
      end
      if (bus.issue_valid && ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_checks++; if (fields !== e) $display("FAIL rnd_order@%0d: got %h want %h", cyc, fields, e); else n_pass++;
        n_checks++; if (cyc - last_any < 2) $display("FAIL rnd_rate@%0d: got gap %0d want >=2", cyc, cyc - last_any); else n_pass++;
        last_acc[bus.issue_bank] = cyc;
        last_any = cyc;
        accepted++;
      end
      prev_stall  = bus.issue_valid && !ready;
      prev_fields = fields;
      done = (pushed == 120) && (exp_q.size() == 0) && bus.idle && bus.q_empty;
    end
    n_checks++; if (!done) $display("FAIL rnd_timeout: got %0d pending want 0", exp_q.size()); else n_pass++;
`ifdef DISPATCH_STATS_EN
    n_checks++; if (bus.stat_issued - iss0 !== 16'(accepted) || bus.stat_nops - nop0 !== 16'(nops))
      $display("FAIL rnd_stats: got %0d/%0d want %0d/%0d", bus.stat_issued - iss0, bus.stat_nops - nop0, accepted, nops); else n_pass++;
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ready = 1'b0; flush = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_two_banks();
    test_nop();
    test_stall_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
